// File: rtl/game_round_ctrl_if.sv
// Keypad/display-side signal bundle for the guessing-game round sequencer.
// The master drives guesses and commands; the slave is the sequencer itself.
interface game_round_ctrl_if;
  logic       iStart;
  logic       iLoad;
  logic [3:0] iNum1;
  logic [3:0] iNum2;
  logic [3:0] iNum3;
  logic       iNumRdy;
  logic [2:0] oState;
  logic [1:0] oHintA;
  logic [1:0] oHintB;
  logic       oHintRdy;
  logic       oBadGuess;
  logic [3:0] oTries;
  logic [3:0] oGuess1;
  logic [3:0] oGuess2;
  logic [3:0] oGuess3;
  logic [3:0] oSecret1;
  logic [3:0] oSecret2;
  logic [3:0] oSecret3;

  modport master (
    output iStart, iLoad, iNum1, iNum2, iNum3, iNumRdy,
    input  oState, oHintA, oHintB, oHintRdy, oBadGuess, oTries,
           oGuess1, oGuess2, oGuess3, oSecret1, oSecret2, oSecret3
  );

  modport slave (
    input  iStart, iLoad, iNum1, iNum2, iNum3, iNumRdy,
    output oState, oHintA, oHintB, oHintRdy, oBadGuess, oTries,
           oGuess1, oGuess2, oGuess3, oSecret1, oSecret2, oSecret3
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round sequencer for the 3-digit xAyB guessing game: owns the secret, scores
// guesses, counts attempts and tracks win/lose. Every output is registered.
module game_round_ctrl #(
  parameter int          MAX_TRIES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  game_round_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    SHOW  = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } state_t;

  // Element 0 is the leftmost digit (iNum1 / LFSR[3:0]).
  typedef logic [2:0][3:0] digits_t;

  function automatic logic is_valid(input digits_t d);
    return (d[0] <= 4'd9) && (d[1] <= 4'd9) && (d[2] <= 4'd9) &&
           (d[0] != d[1]) && (d[0] != d[2]) && (d[1] != d[2]);
  endfunction

  function automatic logic [1:0] count_a(input digits_t g, input digits_t s);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < 3; i++)
      if (g[i] == s[i]) n = n + 2'd1;
    return n;
  endfunction

  // Both sets are valid whenever this is used, so the count never exceeds 3.
  function automatic logic [1:0] count_b(input digits_t g, input digits_t s);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if ((i != j) && (g[i] == s[j])) n = n + 2'd1;
    return n;
  endfunction

  state_t      state_q,    state_d;
  logic [15:0] lfsr_q,     lfsr_d;
  digits_t     secret_q,   secret_d;
  digits_t     guess_q,    guess_d;
  digits_t     osecret_q,  osecret_d;
  logic [1:0]  hint_a_q,   hint_a_d;
  logic [1:0]  hint_b_q,   hint_b_d;
  logic        hint_rdy_q, hint_rdy_d;
  logic        bad_q,      bad_d;
  logic [3:0]  tries_q,    tries_d;

  logic    lfsr_fb;
  digits_t num_in;
  digits_t gen_cand;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign num_in   = {bus.iNum3, bus.iNum2, bus.iNum1};
  assign gen_cand = lfsr_q[11:0];

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_fb};
    secret_d   = secret_q;
    guess_d    = guess_q;
    hint_a_d   = hint_a_q;
    hint_b_d   = hint_b_q;
    hint_rdy_d = 1'b0;
    bad_d      = 1'b0;
    tries_d    = tries_q;

    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d = GEN;
        end else if (bus.iLoad) begin
          if (is_valid(num_in)) begin
            secret_d = num_in;
            tries_d  = '0;
            state_d  = PLAY;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      GEN: begin
        if (is_valid(gen_cand)) begin
          secret_d = gen_cand;
          tries_d  = '0;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (bus.iStart) begin
          state_d = GEN;
        end else if (bus.iNumRdy) begin
          if (is_valid(num_in)) begin
            guess_d = num_in;
            state_d = CHECK;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      CHECK: begin
        hint_a_d   = count_a(guess_q, secret_q);
        hint_b_d   = count_b(guess_q, secret_q);
        tries_d    = tries_q + 4'd1;
        hint_rdy_d = 1'b1;
        state_d    = SHOW;
      end
      SHOW: begin
        if (hint_a_q == 2'd3)                state_d = WIN;
        else if (tries_q == 4'(MAX_TRIES))   state_d = LOSE;
        else                                 state_d = PLAY;
      end
      WIN, LOSE: begin
        if (bus.iStart) state_d = GEN;
      end
      default: state_d = IDLE;
    endcase

    // The secret is only revealed once the round is decided.
    osecret_d = ((state_d == WIN) || (state_d == LOSE)) ? secret_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      secret_q   <= '0;
      guess_q    <= '0;
      osecret_q  <= '0;
      hint_a_q   <= '0;
      hint_b_q   <= '0;
      hint_rdy_q <= 1'b0;
      bad_q      <= 1'b0;
      tries_q    <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      secret_q   <= secret_d;
      guess_q    <= guess_d;
      osecret_q  <= osecret_d;
      hint_a_q   <= hint_a_d;
      hint_b_q   <= hint_b_d;
      hint_rdy_q <= hint_rdy_d;
      bad_q      <= bad_d;
      tries_q    <= tries_d;
    end
  end

  assign bus.oState    = state_q;
  assign bus.oHintA    = hint_a_q;
  assign bus.oHintB    = hint_b_q;
  assign bus.oHintRdy  = hint_rdy_q;
  assign bus.oBadGuess = bad_q;
  assign bus.oTries    = tries_q;
  assign bus.oGuess1   = guess_q[0];
  assign bus.oGuess2   = guess_q[1];
  assign bus.oGuess3   = guess_q[2];
  assign bus.oSecret1  = osecret_q[0];
  assign bus.oSecret2  = osecret_q[1];
  assign bus.oSecret3  = osecret_q[2];

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed round scenarios plus random rounds, with
// hints checked against a scoreboard and GEN exits against an LFSR model.
module tb_game_round_ctrl;

  localparam int          MAXT = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [2:0]  S_IDLE = 3'd0, S_GEN = 3'd1, S_PLAY = 3'd2, S_CHECK = 3'd3,
                          S_SHOW = 3'd4, S_WIN = 3'd5, S_LOSE = 3'd6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  game_round_ctrl_if bus();

  game_round_ctrl #(.MAX_TRIES(MAXT), .LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] t;
  } hint_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  hint_t      sb[$];
  logic [3:0] exp_sec[3];
  int         exp_tries = 0;
  logic [15:0] m_lfsr;
  logic       gen_pend = 1'b0;
  logic [2:0] gen_exp  = S_IDLE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ok3(input int a, input int b, input int c);
    return (a <= 9) && (b <= 9) && (c <= 9) && (a != b) && (a != c) && (b != c);
  endfunction

  // B derived as (digits in common) - A, valid because both sets are distinct.
  function automatic hint_t ref_hint(input int g0, input int g1, input int g2,
                                     input int s0, input int s1, input int s2, input int t);
    hint_t h;
    int    a, common;
    int    g[3];
    g[0] = g0; g[1] = g1; g[2] = g2;
    a = int'(g0 == s0) + int'(g1 == s1) + int'(g2 == s2);
    common = 0;
    for (int i = 0; i < 3; i++)
      if (g[i] == s0 || g[i] == s1 || g[i] == s2) common++;
    h.a = 2'(a);
    h.b = 2'(common - a);
    h.t = 4'(t);
    return h;
  endfunction

  always @(posedge clk)
    m_lfsr <= reset ? SEED : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  always @(negedge clk) begin
    if (gen_pend) begin
      chk("gen_next_state", 32'(bus.oState), 32'(gen_exp));
      gen_pend = 1'b0;
    end
    if (!reset && bus.oState == S_GEN) begin
      gen_pend = 1'b1;
      if (ok3(int'(m_lfsr[3:0]), int'(m_lfsr[7:4]), int'(m_lfsr[11:8]))) begin
        gen_exp    = S_PLAY;
        exp_sec[0] = m_lfsr[3:0];
        exp_sec[1] = m_lfsr[7:4];
        exp_sec[2] = m_lfsr[11:8];
        exp_tries  = 0;
      end else begin
        gen_exp = S_GEN;
      end
    end
    if (bus.oHintRdy) begin
      if (sb.size() == 0) begin
        chk("hint_unexpected", 32'd1, 32'd0);
      end else begin
        hint_t e;
        e = sb.pop_front();
        chk("hint_a", 32'(bus.oHintA), 32'(e.a));
        chk("hint_b", 32'(bus.oHintB), 32'(e.b));
        chk("hint_tries", 32'(bus.oTries), 32'(e.t));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(bus.oState), 32'(S_IDLE));
    chk({tag, "_hint"}, {26'd0, bus.oHintA, bus.oHintB, bus.oHintRdy, bus.oBadGuess}, 32'd0);
    chk({tag, "_tries"}, 32'(bus.oTries), 32'd0);
    chk({tag, "_guess"}, 32'({bus.oGuess1, bus.oGuess2, bus.oGuess3}), 32'd0);
    chk({tag, "_secret"}, 32'({bus.oSecret1, bus.oSecret2, bus.oSecret3}), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero(tag);
  endtask

  task automatic load(input int a, input int b, input int c);
    bus.iNum1 = 4'(a); bus.iNum2 = 4'(b); bus.iNum3 = 4'(c);
    bus.iLoad = 1'b1;
    tick();
    bus.iLoad = 1'b0;
    if (ok3(a, b, c)) begin
      exp_sec[0] = 4'(a); exp_sec[1] = 4'(b); exp_sec[2] = 4'(c);
      exp_tries = 0;
    end
  endtask

  task automatic guess(input int a, input int b, input int c, input bit scored);
    bus.iNum1 = 4'(a); bus.iNum2 = 4'(b); bus.iNum3 = 4'(c);
    bus.iNumRdy = 1'b1;
    if (scored) begin
      exp_tries++;
      sb.push_back(ref_hint(a, b, c, int'(exp_sec[0]), int'(exp_sec[1]), int'(exp_sec[2]),
                            exp_tries));
    end
    tick();
    bus.iNumRdy = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.oState != s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.oState), 32'(s));
  endtask

  task automatic start_round();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    chk("start_gen", 32'(bus.oState), 32'(S_GEN));
    wait_state(S_PLAY, 500, "gen_to_play");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g[3];
    hint_t h;
    bus.iStart = 1'b0; bus.iLoad = 1'b0; bus.iNumRdy = 1'b0;
    bus.iNum1 = '0; bus.iNum2 = '0; bus.iNum3 = '0;
    tick();
    do_reset("por");

    // Two-player load: rejected set, then a good one.
    load(5, 5, 5);
    chk("load_bad_pulse", 32'(bus.oBadGuess), 32'd1);
    chk("load_bad_state", 32'(bus.oState), 32'(S_IDLE));
    tick();
    chk("load_bad_clear", 32'(bus.oBadGuess), 32'd0);
    load(1, 2, 3);
    chk("load_state", 32'(bus.oState), 32'(S_PLAY));
    chk("load_tries", 32'(bus.oTries), 32'd0);
    chk("load_secret_hidden", 32'({bus.oSecret1, bus.oSecret2, bus.oSecret3}), 32'd0);

    // Guess 3,2,1 with iNumRdy held through CHECK and SHOW; extra strobes are dropped.
    bus.iNum1 = 4'd3; bus.iNum2 = 4'd2; bus.iNum3 = 4'd1;
    bus.iNumRdy = 1'b1;
    exp_tries++;
    sb.push_back(ref_hint(3, 2, 1, 1, 2, 3, exp_tries));
    tick();
    chk("g321_check", 32'(bus.oState), 32'(S_CHECK));
    chk("g321_guess", 32'({bus.oGuess1, bus.oGuess2, bus.oGuess3}), 32'h321);
    tick();
    chk("g321_show", 32'(bus.oState), 32'(S_SHOW));
    chk("g321_rdy", 32'(bus.oHintRdy), 32'd1);
    chk("g321_ab", 32'({bus.oHintA, bus.oHintB}), 32'({2'd1, 2'd2}));
    tick();
    bus.iNumRdy = 1'b0;
    chk("g321_back_play", 32'(bus.oState), 32'(S_PLAY));
    chk("g321_rdy_low", 32'(bus.oHintRdy), 32'd0);
    chk("g321_tries", 32'(bus.oTries), 32'd1);

    // Winning guess, then ignored input in WIN.
    guess(1, 2, 3, 1'b1);
    tick(); tick();
    chk("win_state", 32'(bus.oState), 32'(S_WIN));
    chk("win_secret", 32'({bus.oSecret1, bus.oSecret2, bus.oSecret3}), 32'h123);
    chk("win_tries", 32'(bus.oTries), 32'd2);
    chk("win_hint", 32'({bus.oHintA, bus.oHintB}), 32'({2'd3, 2'd0}));
    guess(4, 5, 6, 1'b0);
    tick(); tick();
    chk("win_hold_state", 32'(bus.oState), 32'(S_WIN));
    chk("win_hold_guess", 32'({bus.oGuess1, bus.oGuess2, bus.oGuess3}), 32'h123);
    chk("win_hold_tries", 32'(bus.oTries), 32'd2);
    start_round();
    chk("gen_tries_clear", 32'(bus.oTries), 32'd0);

    // Rejected guesses in PLAY.
    guess(1, 1, 2, 1'b0);
    chk("bad112_pulse", 32'(bus.oBadGuess), 32'd1);
    chk("bad112_state", 32'(bus.oState), 32'(S_PLAY));
    tick();
    chk("bad112_clear", 32'(bus.oBadGuess), 32'd0);
    guess(10, 0, 1, 1'b0);
    chk("badA01_pulse", 32'(bus.oBadGuess), 32'd1);
    chk("badA01_state", 32'(bus.oState), 32'(S_PLAY));
    tick();
    chk("badA01_clear", 32'(bus.oBadGuess), 32'd0);
    chk("bad_tries", 32'(bus.oTries), 32'd0);

    // iStart beats iNumRdy in PLAY.
    bus.iStart = 1'b1;
    guess(4, 5, 6, 1'b0);
    bus.iStart = 1'b0;
    chk("start_prio_gen", 32'(bus.oState), 32'(S_GEN));
    wait_state(S_PLAY, 500, "start_prio_play");

    // Losing round with MAX_TRIES guesses.
    do_reset("rst_lose");
    load(1, 2, 3);
    guess(4, 5, 6, 1'b1); tick(); tick();
    chk("lose_g1_state", 32'(bus.oState), 32'(S_PLAY));
    guess(7, 8, 9, 1'b1); tick(); tick();
    chk("lose_g2_state", 32'(bus.oState), 32'(S_PLAY));
    guess(4, 5, 6, 1'b1); tick(); tick();
    chk("lose_state", 32'(bus.oState), 32'(S_LOSE));
    chk("lose_tries", 32'(bus.oTries), 32'd3);
    chk("lose_secret", 32'({bus.oSecret1, bus.oSecret2, bus.oSecret3}), 32'h123);

    // Reset in the middle of CHECK, then in the middle of GEN.
    start_round();
    guess(9, 8, 7, 1'b0);
    chk("mid_check_state", 32'(bus.oState), 32'(S_CHECK));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rst_check");
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    chk("mid_gen_state", 32'(bus.oState), 32'(S_GEN));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rst_gen");

    // Back-to-back random rounds, one scored guess each.
    for (int r = 0; r < 1000; r++) begin
      start_round();
      if (r % 5 == 0) begin
        g[0] = int'(exp_sec[0]); g[1] = int'(exp_sec[1]); g[2] = int'(exp_sec[2]);
      end else begin
        do begin
          g[0] = int'($urandom_range(0, 9));
          g[1] = int'($urandom_range(0, 9));
          g[2] = int'($urandom_range(0, 9));
        end while (!ok3(g[0], g[1], g[2]));
      end
      h = ref_hint(g[0], g[1], g[2], int'(exp_sec[0]), int'(exp_sec[1]), int'(exp_sec[2]), 1);
      guess(g[0], g[1], g[2], 1'b1);
      tick(); tick();
      chk("rand_state", 32'(bus.oState), (h.a == 2'd3) ? 32'(S_WIN) : 32'(S_PLAY));
    end

    tick(); tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
